// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Command codes, run-controller states and pipeline-depth
//               derived defaults shared by the run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int PIPE_STAGES          = 5;
    // A fetched HALT still has to walk through the remaining stages.
    localparam int DRAIN_CYCLES_DEFAULT = PIPE_STAGES - 1;

    typedef enum logic [1:0] {
        CMD_LOAD  = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_run_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Enable-gated up counter that sticks at all-ones, with a
//               synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_run_ctrl
// Description : Loads instruction memory and sequences the pipeline enable in
//               RUN/STEP mode, stopping once a fetched HALT has drained.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_ctrl
    import pipeline_pkg::*;
#(
    parameter int NBITS        = 32,
    parameter int IMEM_DEPTH   = 256,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int CNT_BITS     = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_cmd_valid,
    input  logic [1:0]                    i_cmd,
    input  logic [NBITS-1:0]              i_cmd_data,
    output logic                          o_cmd_ready,
    input  logic                          i_halt_signal,
    output logic                          o_pipe_enable,
    output logic                          o_pipe_flush,
    output logic                          o_imem_wr_en,
    output logic [$clog2(IMEM_DEPTH)-1:0] o_imem_wr_addr,
    output logic [NBITS-1:0]              o_imem_wr_data,
    output logic [CNT_BITS-1:0]           o_cycle_count,
    output logic [$clog2(IMEM_DEPTH):0]   o_load_count,
    output logic                          o_done,
    output logic                          o_error
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 2);

    localparam logic [LW-1:0] c_depth = LW'(IMEM_DEPTH);
    localparam logic [DW-1:0] c_drain = DW'(DRAIN_CYCLES);

    state_e            r_state;
    state_e            w_state_next;
    logic              r_halted;
    logic [DW-1:0]     r_drain;
    logic [LW-1:0]     r_load_count;
    logic              r_wr_en;
    logic [AW-1:0]     r_wr_addr;
    logic [NBITS-1:0]  r_wr_data;
    logic              r_flush;
    logic              r_error;

    logic              w_enable;
    logic              w_halt_now;
    logic [DW-1:0]     w_drain_inc;
    logic              w_drain_done;
    logic              w_load;
    logic              w_clear;
    logic              w_err;

    assign w_enable    = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_halt_now  = w_enable && i_halt_signal && !r_halted;
    assign w_drain_inc = r_drain + 1'b1;
    // Zero drain means the halt-sampling edge itself ends the program.
    assign w_drain_done = w_enable &&
                          ((w_halt_now && (c_drain == '0)) ||
                           (r_halted && (w_drain_inc == c_drain)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_clear      = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    case (cmd_e'(i_cmd))
                        CMD_LOAD: begin
                            if (r_load_count < c_depth) begin
                                w_load = 1'b1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
                        CMD_RUN:  w_state_next = ST_RUN;
                        CMD_STEP: w_state_next = ST_STEP;
                        default:  w_clear = 1'b1;
                    endcase
                end
            end
            ST_RUN: begin
                if (w_drain_done) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_STEP: begin
                w_state_next = w_drain_done ? ST_DONE : ST_IDLE;
            end
            default: begin
                if (i_cmd_valid) begin
                    if (cmd_e'(i_cmd) == CMD_CLEAR) begin
                        w_clear      = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_halted     <= 1'b0;
            r_drain      <= '0;
            r_load_count <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_flush      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_wr_en <= w_load;
            r_flush <= w_clear;
            r_error <= w_err;
            if (w_load) begin
                r_wr_addr    <= r_load_count[AW-1:0];
                r_wr_data    <= i_cmd_data;
                r_load_count <= r_load_count + 1'b1;
            end
            if (w_clear) begin
                r_load_count <= '0;
                r_halted     <= 1'b0;
                r_drain      <= '0;
            end else if (w_halt_now) begin
                r_halted <= 1'b1;
                r_drain  <= '0;
            end else if (w_enable && r_halted) begin
                r_drain <= w_drain_inc;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_cycle_cnt (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_count  (o_cycle_count)
    );

    assign o_cmd_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign o_pipe_enable  = w_enable;
    assign o_done         = (r_state == ST_DONE);
    assign o_pipe_flush   = r_flush;
    assign o_imem_wr_en   = r_wr_en;
    assign o_imem_wr_addr = r_wr_addr;
    assign o_imem_wr_data = r_wr_data;
    assign o_load_count   = r_load_count;
    assign o_error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_run_ctrl
// Description : Self-checking bench: vector table, hand corner sequences and
//               random commands against a behavioural run-controller model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipeline_run_ctrl;
    import pipeline_pkg::*;

    localparam int DEPTH = 256;
    localparam int DRN   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [31:0] cmd_data;
    logic        halt;

    logic        ready, en, flush, wr_en, done, err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data, cc;
    logic [8:0]  lc;

    logic        s_ready, s_en, s_flush, s_wr_en, s_done, s_err;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data, s_cc;
    logic [2:0]  s_lc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_run_ctrl #(
        .NBITS(32), .IMEM_DEPTH(DEPTH), .DRAIN_CYCLES(DRN), .CNT_BITS(32)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_cmd_data(cmd_data), .o_cmd_ready(ready), .i_halt_signal(halt),
        .o_pipe_enable(en), .o_pipe_flush(flush), .o_imem_wr_en(wr_en),
        .o_imem_wr_addr(wr_addr), .o_imem_wr_data(wr_data),
        .o_cycle_count(cc), .o_load_count(lc), .o_done(done), .o_error(err)
    );

    // Small memory and zero drain exercise the boundary behaviour.
    pipeline_run_ctrl #(
        .NBITS(32), .IMEM_DEPTH(4), .DRAIN_CYCLES(0), .CNT_BITS(32)
    ) dut_small (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .i_cmd_data(cmd_data), .o_cmd_ready(s_ready), .i_halt_signal(halt),
        .o_pipe_enable(s_en), .o_pipe_flush(s_flush), .o_imem_wr_en(s_wr_en),
        .o_imem_wr_addr(s_wr_addr), .o_imem_wr_data(s_wr_data),
        .o_cycle_count(s_cc), .o_load_count(s_lc), .o_done(s_done), .o_error(s_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] d, input logic h);
        cmd_valid = v;
        cmd       = c;
        cmd_data  = d;
        halt      = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic e_en, input logic e_rdy,
                            input logic e_wr, input logic [7:0] e_addr, input logic [31:0] e_data,
                            input logic e_done, input logic e_err, input logic e_flush,
                            input logic [8:0] e_lc, input logic [31:0] e_cc);
        chk({tag, ".enable"}, en,    e_en);
        chk({tag, ".ready"},  ready, e_rdy);
        chk({tag, ".wr_en"},  wr_en, e_wr);
        if (e_wr) begin
            chk({tag, ".wr_addr"}, wr_addr, e_addr);
            chk({tag, ".wr_data"}, wr_data, e_data);
        end
        chk({tag, ".done"},   done,  e_done);
        chk({tag, ".error"},  err,   e_err);
        chk({tag, ".flush"},  flush, e_flush);
        chk({tag, ".load_cnt"},  lc, e_lc);
        chk({tag, ".cycle_cnt"}, cc, e_cc);
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  c;
        logic [31:0] d;
        logic        h;
        logic        en, rdy, wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        done, err, flush;
        logic [8:0]  lc;
        logic [31:0] cc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic v, logic [1:0] c, logic [31:0] d, logic h,
                                logic e_en, logic e_rdy, logic e_wr, logic [7:0] e_addr,
                                logic [31:0] e_data, logic e_done, logic e_err, logic e_flush,
                                logic [8:0] e_lc, logic [31:0] e_cc);
        vec_t r;
        r.v = v; r.c = c; r.d = d; r.h = h;
        r.en = e_en; r.rdy = e_rdy; r.wr = e_wr; r.addr = e_addr; r.wdata = e_data;
        r.done = e_done; r.err = e_err; r.flush = e_flush; r.lc = e_lc; r.cc = e_cc;
        return r;
    endfunction

    // Behavioural model: program mode, halt bookkeeping and counters.
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DONE = 3;
    int          m_mode;
    bit          m_halted;
    int          m_after;
    int          m_loaded;
    logic [31:0] m_cycles;
    bit          m_wr, m_err, m_flush;
    int          m_addr;
    logic [31:0] m_data;

    function automatic void model_reset();
        m_mode = M_IDLE; m_halted = 0; m_after = 0; m_loaded = 0; m_cycles = '0;
        m_wr = 0; m_err = 0; m_flush = 0; m_addr = 0; m_data = '0;
    endfunction

    function automatic void model_edge();
        bit enab;
        enab    = (m_mode == M_RUN) || (m_mode == M_STEP);
        m_wr    = 0;
        m_err   = 0;
        m_flush = 0;
        if (enab) begin
            if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
            if (m_halted) m_after++;
            else if (halt) begin
                m_halted = 1;
                m_after  = 0;
            end
            if (m_halted && (m_after == DRN)) m_mode = M_DONE;
            else if (m_mode == M_STEP)        m_mode = M_IDLE;
        end else if (cmd_valid) begin
            if (cmd == CMD_CLEAR) begin
                m_flush = 1; m_cycles = '0; m_loaded = 0; m_halted = 0; m_after = 0;
                m_mode  = M_IDLE;
            end else if (m_mode == M_DONE) begin
                m_err = 1;
            end else if (cmd == CMD_LOAD) begin
                if (m_loaded < DEPTH) begin
                    m_wr = 1; m_addr = m_loaded; m_data = cmd_data; m_loaded++;
                end else begin
                    m_err = 1;
                end
            end else if (cmd == CMD_RUN) begin
                m_mode = M_RUN;
            end else begin
                m_mode = M_STEP;
            end
        end
    endfunction

    initial begin
        rst = 1'b1;
        drive(0, 2'b00, 32'h0, 0);
        #1;
        chk_main("reset", 0, 1, 0, 8'h0, 32'h0, 0, 0, 0, 9'd0, 32'd0);
        chk("reset.wr_addr", wr_addr, 8'h0);
        chk("reset.wr_data", wr_data, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Load, run to halt+drain, DONE rejection, clear, then single steps.
        vt.push_back(mk(1, CMD_LOAD, 32'hAAAA0001, 0, 0,1,1,8'd0,32'hAAAA0001,0,0,0,9'd1,32'd0));
        vt.push_back(mk(1, CMD_LOAD, 32'hAAAA0002, 0, 0,1,1,8'd1,32'hAAAA0002,0,0,0,9'd2,32'd0));
        vt.push_back(mk(1, CMD_LOAD, 32'hAAAA0003, 0, 0,1,1,8'd2,32'hAAAA0003,0,0,0,9'd3,32'd0));
        vt.push_back(mk(1, CMD_RUN,  32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd3,32'd0));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd3,32'd1));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd3,32'd2));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd3,32'd3));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd3,32'd4));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 1, 1,0,0,8'd0,32'h0,0,0,0,9'd3,32'd5));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 1, 1,0,0,8'd0,32'h0,0,0,0,9'd3,32'd6));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd3,32'd7));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd3,32'd8));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 0,1,0,8'd0,32'h0,1,0,0,9'd3,32'd9));
        vt.push_back(mk(1, CMD_RUN,  32'h0, 0, 0,1,0,8'd0,32'h0,1,1,0,9'd3,32'd9));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 0,1,0,8'd0,32'h0,1,0,0,9'd3,32'd9));
        vt.push_back(mk(1, CMD_CLEAR,32'h0, 0, 0,1,0,8'd0,32'h0,0,0,1,9'd0,32'd0));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 0,1,0,8'd0,32'h0,0,0,0,9'd0,32'd0));
        vt.push_back(mk(1, CMD_STEP, 32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd0,32'd0));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 0,1,0,8'd0,32'h0,0,0,0,9'd0,32'd1));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 1, 0,1,0,8'd0,32'h0,0,0,0,9'd0,32'd1));
        vt.push_back(mk(1, CMD_STEP, 32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd0,32'd1));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 0,1,0,8'd0,32'h0,0,0,0,9'd0,32'd2));
        vt.push_back(mk(1, CMD_STEP, 32'h0, 0, 1,0,0,8'd0,32'h0,0,0,0,9'd0,32'd2));
        vt.push_back(mk(0, CMD_LOAD, 32'h0, 0, 0,1,0,8'd0,32'h0,0,0,0,9'd0,32'd3));
        vt.push_back(mk(1, CMD_LOAD, 32'h1234, 0, 0,1,1,8'd0,32'h1234,0,0,0,9'd1,32'd3));

        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].c, vt[i].d, vt[i].h);
            tick();
            chk_main($sformatf("vec%0d", i), vt[i].en, vt[i].rdy, vt[i].wr, vt[i].addr,
                     vt[i].wdata, vt[i].done, vt[i].err, vt[i].flush, vt[i].lc, vt[i].cc);
        end

        // Asynchronous reset in the middle of a run.
        drive(1, CMD_RUN, 32'h0, 0);
        tick();
        drive(0, CMD_LOAD, 32'h0, 0);
        tick();
        tick();
        chk("async.pre_enable", en, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async.enable_drop", en, 1'b0);
        chk("async.cycle_cnt", cc, 32'd0);
        chk("async.flush", flush, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_main("async.after", 0, 1, 0, 8'h0, 32'h0, 0, 0, 0, 9'd0, 32'd0);

        // Four-word memory, zero drain.
        for (int i = 0; i < 5; i++) begin
            drive(1, CMD_LOAD, 32'h5000_0000 + i, 0);
            tick();
            chk($sformatf("small.load%0d.wr_en", i), s_wr_en, (i < 4));
            chk($sformatf("small.load%0d.error", i), s_err, (i == 4));
            chk($sformatf("small.load%0d.count", i), s_lc, (i < 4) ? i + 1 : 4);
            if (i < 4) begin
                chk($sformatf("small.load%0d.addr", i), s_wr_addr, i);
                chk($sformatf("small.load%0d.data", i), s_wr_data, 32'h5000_0000 + i);
            end
        end
        drive(0, CMD_LOAD, 32'h0, 0);
        tick();
        chk("small.err_clear", s_err, 1'b0);
        drive(1, CMD_RUN, 32'h0, 0);
        tick();
        chk("small.run.enable", s_en, 1'b1);
        drive(0, CMD_LOAD, 32'h0, 1);
        tick();
        chk("small.halt0.enable", s_en, 1'b0);
        chk("small.halt0.done", s_done, 1'b1);
        chk("small.halt0.cycles", s_cc, 32'd1);
        drive(1, CMD_CLEAR, 32'h0, 0);
        tick();
        chk("small.clear.flush", s_flush, 1'b1);
        chk("small.clear.done", s_done, 1'b0);
        chk("small.clear.count", s_lc, 3'd0);
        drive(1, CMD_STEP, 32'h0, 1);
        tick();
        chk("small.step.enable", s_en, 1'b1);
        chk("small.step.flush", s_flush, 1'b0);
        drive(0, CMD_LOAD, 32'h0, 1);
        tick();
        chk("small.stephalt.done", s_done, 1'b1);
        chk("small.stephalt.enable", s_en, 1'b0);
        chk("small.stephalt.cycles", s_cc, 32'd1);

        // Random commands against the model.
        drive(0, CMD_LOAD, 32'h0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [1:0] c;
            r = $urandom_range(0, 9);
            c = (r < 4) ? CMD_LOAD : (r < 6) ? CMD_RUN : (r < 9) ? CMD_STEP : CMD_CLEAR;
            drive(($urandom_range(0, 1) == 1), c, $urandom, ($urandom_range(0, 5) == 0));
            tick();
            model_edge();
            chk_main($sformatf("rnd%0d", i), (m_mode == M_RUN) || (m_mode == M_STEP),
                     (m_mode == M_IDLE) || (m_mode == M_DONE), m_wr, m_addr[7:0], m_data,
                     (m_mode == M_DONE), m_err, m_flush, m_loaded[8:0], m_cycles);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
